la_capture_core: RTL and testbench

Parametrised successor to the 2-channel logic-analyser front end. It samples CH_NUM asynchronous inputs on a programmable divider tick and qualifies the start of capture with a maskable trigger. Samples are packed into bytes and pushed to the downstream capture FIFO. A capture runs for a programmed byte count and reports overflow and drops. The block sits between the pin inputs and the capture FIFO, and the host-side register block configures it.

---
 rtl/la_pkg.sv | 21 ++
 rtl/la_sample_packer.sv | 43 ++++
 rtl/la_capture_core.sv | 159 +++++++++++++++
 tb/tb_la_capture_core.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared encodings for the logic-analyser capture core: FSM states, trigger
// modes and the channel-count legality check.
package la_pkg;

  typedef enum logic [1:0] {
    LA_IDLE    = 2'd0,
    LA_ARMED   = 2'd1,
    LA_CAPTURE = 2'd2,
    LA_DONE    = 2'd3
  } la_state_e;

  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_CHG  = 2'd1;
  localparam logic [1:0] TRIG_PAT  = 2'd2;
  localparam logic [1:0] TRIG_EDGE = 2'd3;

  function automatic bit ch_num_legal(input int n);
    return (n == 1) || (n == 2) || (n == 4) || (n == 8);
  endfunction

endpackage

// File: rtl/la_sample_packer.sv
// Per-channel shift registers that pack SPB samples of every channel into one
// byte; byte_o/byte_vld_o present the completed byte in the completing tick.
module la_sample_packer #(
  parameter int CH_NUM = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_i,
  input  logic              flush_i,
  input  logic [CH_NUM-1:0] din_s_i,
  output logic [7:0]        byte_o,
  output logic              byte_vld_o
);
  localparam int SPB = 8 / CH_NUM;

  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q;

  // Channel c owns bits [c*SPB +: SPB]; the newest sample enters at the lane LSB.
  always_comb begin
    sr_d = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      sr_d[c*SPB] = din_s_i[c];
      for (int b = 1; b < SPB; b++) begin
        sr_d[c*SPB+b] = sr_q[c*SPB+b-1];
      end
    end
  end

  assign byte_o     = sr_d;
  assign byte_vld_o = tick_i && (cnt_q == 3'(SPB - 1));

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (tick_i) begin
      sr_q  <= sr_d;
      cnt_q <= byte_vld_o ? 3'd0 : cnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser front end: synchronises the pins, waits for a masked trigger,
// samples on a divider tick and streams packed bytes to the capture FIFO.
module la_capture_core
  import la_pkg::*;
#(
  parameter int CH_NUM = 2,
  parameter int DIV_W  = 13,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_NUM-1:0] din,
  input  logic              cfg_valid,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_trig_mode,
  input  logic [CH_NUM-1:0] cfg_trig_mask,
  input  logic [CH_NUM-1:0] cfg_trig_val,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              cfg_stall_en,
  input  logic              arm,
  input  logic              abort,
  output logic [7:0]        fifo_wdata,
  output logic              fifo_wen,
  input  logic              fifo_full,
  input  logic              fifo_alfull,
  output logic [1:0]        state,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_cnt
);
  if (!ch_num_legal(CH_NUM)) begin : g_bad_ch_num
    $error("la_capture_core: CH_NUM must be 1, 2, 4 or 8");
  end

  la_state_e         state_q;
  logic [CH_NUM-1:0] din_m_q, din_s_q, din_p_q;
  logic [DIV_W-1:0]  cfg_div_q, div_cnt_q;
  logic [1:0]        cfg_mode_q;
  logic [CH_NUM-1:0] cfg_mask_q, cfg_val_q;
  logic [CNT_W-1:0]  cfg_len_q, byte_cnt_q, drop_cnt_q, drop_cnt_d;
  logic              cfg_stall_q;
  logic [7:0]        fifo_wdata_q;
  logic              fifo_wen_q, done_q, overflow_q;
  logic              trig_hit, freeze, tick, flush, byte_last, can_start;
  logic [7:0]        pk_byte;
  logic              pk_vld;

  always_comb begin
    trig_hit = 1'b0;
    case (cfg_mode_q)
      TRIG_IMM: trig_hit = 1'b1;
      TRIG_CHG: trig_hit = |((din_s_q ^ din_p_q) & cfg_mask_q);
      TRIG_PAT: trig_hit = (cfg_mask_q != '0) && (((din_s_q ^ cfg_val_q) & cfg_mask_q) == '0);
      default:  trig_hit = |(cfg_mask_q & (din_p_q ^ cfg_val_q) & ~(din_s_q ^ cfg_val_q));
    endcase
  end

  assign can_start  = (state_q == LA_IDLE) || (state_q == LA_DONE);
  assign freeze     = (state_q == LA_CAPTURE) && cfg_stall_q && fifo_alfull;
  // The trigger cycle itself is sample 0.
  assign tick       = ((state_q == LA_ARMED) && trig_hit) ||
                      ((state_q == LA_CAPTURE) && !freeze && (div_cnt_q == cfg_div_q));
  assign flush      = abort || can_start;
  assign byte_last  = (cfg_len_q != '0) && ((byte_cnt_q + CNT_W'(1)) == cfg_len_q);
  assign drop_cnt_d = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + CNT_W'(1);

  la_sample_packer #(.CH_NUM(CH_NUM)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .tick_i    (tick),
    .flush_i   (flush),
    .din_s_i   (din_s_q),
    .byte_o    (pk_byte),
    .byte_vld_o(pk_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LA_IDLE;
      din_m_q      <= '0;
      din_s_q      <= '0;
      din_p_q      <= '0;
      cfg_div_q    <= '0;
      cfg_mode_q   <= '0;
      cfg_mask_q   <= '0;
      cfg_val_q    <= '0;
      cfg_len_q    <= '0;
      cfg_stall_q  <= 1'b0;
      div_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      fifo_wdata_q <= '0;
      fifo_wen_q   <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      din_m_q    <= din;
      din_s_q    <= din_m_q;
      din_p_q    <= din_s_q;
      fifo_wen_q <= 1'b0;
      done_q     <= 1'b0;
      if (abort) begin
        state_q <= LA_IDLE;
      end else begin
        if (can_start && cfg_valid) begin
          cfg_div_q   <= cfg_div;
          cfg_mode_q  <= cfg_trig_mode;
          cfg_mask_q  <= cfg_trig_mask;
          cfg_val_q   <= cfg_trig_val;
          cfg_len_q   <= cfg_len;
          cfg_stall_q <= cfg_stall_en;
        end
        case (state_q)
          LA_IDLE, LA_DONE: begin
            if (arm) begin
              state_q    <= LA_ARMED;
              div_cnt_q  <= '0;
              byte_cnt_q <= '0;
              drop_cnt_q <= '0;
              overflow_q <= 1'b0;
            end
          end
          LA_ARMED: begin
            if (trig_hit) begin
              state_q   <= LA_CAPTURE;
              div_cnt_q <= '0;
            end
          end
          default: begin
            if (!freeze) div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
          end
        endcase
        // A dropped byte still advances the byte count toward cfg_len.
        if (pk_vld) begin
          fifo_wdata_q <= pk_byte;
          byte_cnt_q   <= byte_cnt_q + CNT_W'(1);
          if (fifo_full) begin
            overflow_q <= 1'b1;
            drop_cnt_q <= drop_cnt_d;
          end else begin
            fifo_wen_q <= 1'b1;
          end
          if (byte_last) begin
            state_q <= LA_DONE;
            done_q  <= 1'b1;
          end
        end
      end
    end
  end

  assign state      = state_q;
  assign fifo_wdata = fifo_wdata_q;
  assign fifo_wen   = fifo_wen_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core (CH_NUM=2): expected bytes and their
// write cycles are queued by the stimulus and checked by a FIFO-side monitor.
module tb_la_capture_core;
  localparam int CH_NUM = 2;
  localparam int DIV_W  = 13;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH_NUM-1:0] din;
  logic              cfg_valid;
  logic [DIV_W-1:0]  cfg_div;
  logic [1:0]        cfg_trig_mode;
  logic [CH_NUM-1:0] cfg_trig_mask;
  logic [CH_NUM-1:0] cfg_trig_val;
  logic [CNT_W-1:0]  cfg_len;
  logic              cfg_stall_en;
  logic              arm;
  logic              abort;
  logic [7:0]        fifo_wdata;
  logic              fifo_wen;
  logic              fifo_full;
  logic              fifo_alfull;
  logic [1:0]        state;
  logic              done;
  logic              overflow;
  logic [CNT_W-1:0]  drop_cnt;

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         t0;
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];

  la_capture_core #(.CH_NUM(CH_NUM), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .cfg_valid    (cfg_valid),
    .cfg_div      (cfg_div),
    .cfg_trig_mode(cfg_trig_mode),
    .cfg_trig_mask(cfg_trig_mask),
    .cfg_trig_val (cfg_trig_val),
    .cfg_len      (cfg_len),
    .cfg_stall_en (cfg_stall_en),
    .arm          (arm),
    .abort        (abort),
    .fifo_wdata   (fifo_wdata),
    .fifo_wen     (fifo_wen),
    .fifo_full    (fifo_full),
    .fifo_alfull  (fifo_alfull),
    .state        (state),
    .done         (done),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
  );

  // Clock and cycle index; a "cycle" is the window between two rising edges.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input int div, input int mode, input int mask, input int val,
                         input int len, input bit stall);
    cfg_div       = DIV_W'(div);
    cfg_trig_mode = 2'(mode);
    cfg_trig_mask = CH_NUM'(mask);
    cfg_trig_val  = CH_NUM'(val);
    cfg_len       = CNT_W'(len);
    cfg_stall_en  = stall;
  endtask

  // Holds cfg_valid/arm for the current cycle only.
  task automatic issue(input bit c, input bit a);
    cfg_valid = c;
    arm       = a;
    step(1);
    cfg_valid = 1'b0;
    arm       = 1'b0;
  endtask

  task automatic expect_byte(input logic [7:0] b, input int at_cyc);
    exp_q.push_back(b);
    exp_cyc_q.push_back(at_cyc);
  endtask

  // Scoreboard monitor: every write strobe must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && fifo_wen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wen: got data %0h at cycle %0d, required no write", fifo_wdata, cyc);
      end else begin
        logic [7:0] eb;
        int         ec;
        eb = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("wdata", 32'(fifo_wdata), 32'(eb));
        check("wen_cycle", 32'(cyc), 32'(ec));
      end
    end
  end

  initial begin
    rst = 1'b1; din = '0; cfg_valid = 1'b0; arm = 1'b0; abort = 1'b0;
    fifo_full = 1'b0; fifo_alfull = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 1'b0);
    step(3);
    check("rst_state", 32'(state), 32'd0);
    check("rst_wen", 32'(fifo_wen), 32'd0);
    check("rst_wdata", 32'(fifo_wdata), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;

    // Immediate trigger, div 0, two bytes of din=01, cfg loaded with arm.
    din = 2'b01;
    set_cfg(0, 0, 0, 0, 2, 1'b0);
    step(3);
    t0 = cyc;
    expect_byte(8'h0F, t0 + 5);
    expect_byte(8'h0F, t0 + 9);
    issue(1'b1, 1'b1);
    check("t1_armed", 32'(state), 32'd1);
    step(8);
    check("t1_done", 32'(done), 32'd1);
    check("t1_state_done", 32'(state), 32'd3);
    step(1);
    check("t1_done_pulse", 32'(done), 32'd0);

    // Pattern trigger 10 on mask 11; samples 10,10,01,11 -> ch1=1101 ch0=0011.
    din = 2'b00;
    set_cfg(0, 2, 2'b11, 2'b10, 1, 1'b0);
    step(3);
    issue(1'b1, 1'b1);
    step(10);
    check("t2_still_armed", 32'(state), 32'd1);
    t0 = cyc;
    din = 2'b10;
    expect_byte(8'hD3, t0 + 6);
    step(2); din = 2'b01;
    step(1); din = 2'b11;
    step(1); din = 2'b00;
    step(4);
    check("t2_state_done", 32'(state), 32'd3);

    // Divider 4: ch0 sampled as 1,0,1,0 at 5-cycle spacing.
    set_cfg(4, 0, 0, 0, 1, 1'b0);
    step(2);
    din = 2'b01;
    step(1);
    t0 = cyc;
    expect_byte(8'h0A, t0 + 17);
    issue(1'b1, 1'b1);
    step(3); din = 2'b00;
    step(5); din = 2'b01;
    step(5); din = 2'b00;
    step(5);
    check("t3_state_done", 32'(state), 32'd3);

    // Drop mode with FIFO full: three drops, then arm clears the flags.
    fifo_full = 1'b1;
    set_cfg(0, 0, 0, 0, 3, 1'b0);
    step(1);
    issue(1'b1, 1'b1);
    step(4);
    check("t4_overflow_first", 32'(overflow), 32'd1);
    check("t4_drop_first", 32'(drop_cnt), 32'd1);
    step(8);
    check("t4_done", 32'(done), 32'd1);
    check("t4_state_done", 32'(state), 32'd3);
    check("t4_drop_cnt", 32'(drop_cnt), 32'd3);
    fifo_full = 1'b0;
    set_cfg(0, 2, 0, 0, 1, 1'b0);
    issue(1'b1, 1'b1);
    check("t4_overflow_clr", 32'(overflow), 32'd0);
    check("t4_drop_clr", 32'(drop_cnt), 32'd0);
    check("t4_rearmed", 32'(state), 32'd1);
    step(3);
    check("t4_mask0_no_trig", 32'(state), 32'd1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("t4_abort_idle", 32'(state), 32'd0);

    // Stall: alfull for 7 cycles after two samples; frozen cycles drive din=10.
    set_cfg(0, 0, 0, 0, 1, 1'b1);
    step(1);
    din = 2'b01;
    step(1);
    t0 = cyc;
    din = 2'b00;
    expect_byte(8'h0B, t0 + 12);
    issue(1'b1, 1'b1);
    din = 2'b10;
    step(2); fifo_alfull = 1'b1;
    step(1);
    check("t5_stalled_capture", 32'(state), 32'd2);
    step(4); din = 2'b01;
    step(2); fifo_alfull = 1'b0; din = 2'b00;
    step(4);
    check("t5_state_done", 32'(state), 32'd3);

    // Abort with arm during sample 2; the following capture must be clean.
    set_cfg(0, 0, 0, 0, 1, 1'b0);
    din = 2'b11;
    step(3);
    issue(1'b1, 1'b1);
    step(2);
    abort = 1'b1;
    arm   = 1'b1;
    step(1);
    abort = 1'b0;
    arm   = 1'b0;
    check("t6_abort_idle", 32'(state), 32'd0);
    din = 2'b01;
    step(6);
    check("t6_still_idle", 32'(state), 32'd0);
    t0 = cyc;
    expect_byte(8'h0F, t0 + 5);
    issue(1'b0, 1'b1);
    step(6);
    check("t6_state_done", 32'(state), 32'd3);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
